// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared-memory datapath, and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             branch,
  output logic             pc_update,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             adr_src,
  output logic [1:0]       alu_op,
  output logic             mem_req,
  output logic             illegal,
  output logic [4:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_EXEC_R    = 5'd2,
    S_EXEC_I    = 5'd3,
    S_ALU_WB    = 5'd4,
    S_MEM_ADR   = 5'd5,
    S_MEM_READ  = 5'd6,
    S_MEM_WB    = 5'd7,
    S_MEM_WRITE = 5'd8,
    S_BRANCH    = 5'd9,
    S_JAL       = 5'd10,
    S_JALR      = 5'd11,
    S_JALR_WB   = 5'd12,
    S_LUI       = 5'd13,
    S_AUIPC     = 5'd14,
    S_TRAP      = 5'd15
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       illegal;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   rdy;
  logic   retire;
  logic   in_fetch;
  logic   active;

  // Moore control word of a state; the rdy-qualified FETCH strobes are added at the outputs.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_EXEC_R:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXEC_I:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALU_WB:    c.reg_write = 1'b1;
      S_MEM_ADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEM_READ:  begin c.adr_src = 1'b1; c.mem_req = 1'b1; end
      S_MEM_WB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEM_WRITE: begin c.adr_src = 1'b1; c.mem_req = 1'b1; c.mem_write = 1'b1; end
      S_BRANCH:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:       begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      S_JALR:      begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      S_JALR_WB:   begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.reg_write = 1'b1;
      end
      S_LUI:       begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      S_AUIPC:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_TRAP:      c.illegal = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state)
      S_FETCH:  state_next = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:             state_next = S_EXEC_R;
          OP_I:             state_next = S_EXEC_I;
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_BR:            state_next = S_BRANCH;
          OP_JAL:           state_next = S_JAL;
          OP_JALR:          state_next = S_JALR;
          OP_LUI:           state_next = S_LUI;
          OP_AUIPC:         state_next = S_AUIPC;
          default:          state_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC: state_next = S_ALU_WB;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JALR_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_ADR:   state_next = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_next = rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        state_next = rdy ? S_FETCH : S_MEM_WRITE;
        retire     = rdy;
      end
      S_JALR:      state_next = S_JALR_WB;
      S_TRAP:      state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so it lines up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
      instret <= '0;
    end else begin
      state  <= state_next;
      ctrl_q <= decode(state_next);
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  assign state_o  = state;
  assign in_fetch = (state == S_FETCH);
  // Reset and any unused state code silence every control output immediately.
  assign active   = !reset && (state_o <= 5'd15);

  assign branch     = active & ctrl_q.branch;
  assign pc_update  = active & (ctrl_q.pc_update | (in_fetch & rdy));
  assign reg_write  = active & ctrl_q.reg_write;
  assign mem_write  = active & ctrl_q.mem_write;
  assign ir_write   = active & in_fetch & rdy;
  assign result_src = {2{active}} & ctrl_q.result_src;
  assign alu_src_a  = {2{active}} & ctrl_q.alu_src_a;
  assign alu_src_b  = {2{active}} & ctrl_q.alu_src_b;
  assign adr_src    = active & ctrl_q.adr_src;
  assign alu_op     = {2{active}} & ctrl_q.alu_op;
  assign mem_req    = active & ctrl_q.mem_req;
  assign illegal    = active & ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: an instruction-level model predicts the state walk,
// control word and retire count of two differently parameterised instances.
module tb_multicycle_ctrl_fsm;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic       a_reset, a_ready, b_reset, b_ready;
  logic [6:0] a_op, b_op;

  logic a_branch, a_pc_update, a_reg_write, a_mem_write, a_ir_write, a_adr_src, a_mem_req, a_illegal;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op;
  logic [4:0] a_state;
  logic [31:0] a_instret;

  logic b_branch, b_pc_update, b_reg_write, b_mem_write, b_ir_write, b_adr_src, b_mem_req, b_illegal;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
  logic [4:0] b_state;
  logic [3:0] b_instret;

  logic [15:0] a_vec, b_vec;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0010011};

  multicycle_ctrl_fsm dut_a (
    .clk(clk), .reset(a_reset), .op(a_op), .mem_ready(a_ready),
    .branch(a_branch), .pc_update(a_pc_update), .reg_write(a_reg_write), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .result_src(a_result_src), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .adr_src(a_adr_src), .alu_op(a_alu_op), .mem_req(a_mem_req),
    .illegal(a_illegal), .state_o(a_state), .instret(a_instret)
  );

  multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .op(b_op), .mem_ready(b_ready),
    .branch(b_branch), .pc_update(b_pc_update), .reg_write(b_reg_write), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .result_src(b_result_src), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .adr_src(b_adr_src), .alu_op(b_alu_op), .mem_req(b_mem_req),
    .illegal(b_illegal), .state_o(b_state), .instret(b_instret)
  );

  assign a_vec = {a_branch, a_pc_update, a_reg_write, a_mem_write, a_ir_write, a_mem_req,
                  a_illegal, a_adr_src, a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op};
  assign b_vec = {b_branch, b_pc_update, b_reg_write, b_mem_write, b_ir_write, b_mem_req,
                  b_illegal, b_adr_src, b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for a state code, straight from the per-state output table.
  function automatic logic [15:0] exp_vec(input int s, input bit rdy);
    logic br, pcu, rw, mw, irw, mrq, ill, adr;
    logic [1:0] rs, a, b, aop;
    {br, pcu, rw, mw, irw, mrq, ill, adr} = '0;
    rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
    case (s)
      0:  begin mrq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; aop = 2'b10; end
      3:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      4:  rw = 1;
      5:  begin a = 2'b10; b = 2'b01; end
      6:  begin adr = 1; mrq = 1; end
      7:  begin rs = 2'b01; rw = 1; end
      8:  begin adr = 1; mrq = 1; mw = 1; end
      9:  begin a = 2'b10; aop = 2'b01; br = 1; end
      10: begin a = 2'b01; b = 2'b10; pcu = 1; end
      11: begin a = 2'b10; b = 2'b01; rs = 2'b10; pcu = 1; end
      12: begin a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1; end
      13: begin a = 2'b11; b = 2'b01; end
      14: begin a = 2'b01; b = 2'b01; end
      15: ill = 1;
      default: ;
    endcase
    return {br, pcu, rw, mw, irw, mrq, ill, adr, rs, a, b, aop};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkState(input int inst, input int s, input bit rdy);
    string t;
    t = $sformatf("u%0d st%0d", inst, s);
    if (inst == 0) begin
      checkOutput({t, " state"}, 32'(a_state), 32'(s));
      checkOutput({t, " ctrl"}, 32'(a_vec), 32'(exp_vec(s, rdy)));
      checkOutput({t, " instret"}, a_instret, cnt_a);
    end else begin
      checkOutput({t, " state"}, 32'(b_state), 32'(s));
      checkOutput({t, " ctrl"}, 32'(b_vec), 32'(exp_vec(s, rdy)));
      checkOutput({t, " instret"}, 32'(b_instret), 32'(cnt_b));
    end
  endtask

  // One state of the walk; memory states repeat while the effective ready is low.
  task automatic stepState(input int inst, input int s, input int waits);
    int w;
    bit r, eff, stall, ret;
    w = 0;
    do begin
      if (waits >= 0) r = (w >= waits);
      else r = (w >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (inst == 0) a_ready = r; else b_ready = r;
      #1;
      eff = (inst == 0) ? r : 1'b1;
      checkState(inst, s, eff);
      stall = (s == 0 || s == 6 || s == 8) && !eff;
      ret = (s == 4 || s == 7 || s == 9 || s == 12) || (s == 8 && eff);
      @(posedge clk);
      if (ret) begin
        if (inst == 0) cnt_a = cnt_a + 32'd1; else cnt_b = cnt_b + 4'd1;
      end
      @(negedge clk);
      w++;
    end while (stall);
  endtask

  // Runs one instruction through the state walk its opcode class implies.
  task automatic applyStimulus(input int inst, input logic [6:0] opc, input int waits);
    int path [6];
    int n;
    path = '{0, 1, 15, 15, 15, 15};
    n = 3;
    case (opc)
      7'b0110011: begin path[2] = 2;  path[3] = 4;  n = 4; end
      7'b0010011: begin path[2] = 3;  path[3] = 4;  n = 4; end
      7'b0000011: begin path[2] = 5;  path[3] = 6;  path[4] = 7; n = 5; end
      7'b0100011: begin path[2] = 5;  path[3] = 8;  n = 4; end
      7'b1100011: begin path[2] = 9;  n = 3; end
      7'b1101111: begin path[2] = 10; path[3] = 4;  n = 4; end
      7'b1100111: begin path[2] = 11; path[3] = 12; n = 4; end
      7'b0110111: begin path[2] = 13; path[3] = 4;  n = 4; end
      7'b0010111: begin path[2] = 14; path[3] = 4;  n = 4; end
      default:    n = (inst == 0) ? 6 : 3;
    endcase
    if (inst == 0) a_op = opc; else b_op = opc;
    for (int i = 0; i < n; i++) stepState(inst, path[i], waits);
  endtask

  task automatic doReset(input int inst, input int pre);
    if (inst == 0) begin a_reset = 1'b1; a_ready = 1'b0; end
    else begin b_reset = 1'b1; b_ready = 1'b0; end
    #1;
    checkOutput($sformatf("u%0d reset ctrl", inst), 32'(inst == 0 ? a_vec : b_vec), 32'd0);
    if (pre >= 0)
      checkOutput($sformatf("u%0d reset prestate", inst), 32'(inst == 0 ? a_state : b_state), 32'(pre));
    @(posedge clk);
    @(negedge clk);
    if (inst == 0) cnt_a = '0; else cnt_b = '0;
    checkOutput($sformatf("u%0d reset state", inst), 32'(inst == 0 ? a_state : b_state), 32'd0);
    checkOutput($sformatf("u%0d reset instret", inst),
                inst == 0 ? a_instret : 32'(b_instret), 32'd0);
    if (inst == 0) a_reset = 1'b0; else b_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
    a_op = 7'd0; b_op = 7'd0; cnt_a = '0; cnt_b = '0;
    $display("[TB] start");
    @(negedge clk);

    doReset(0, -1);
    applyStimulus(0, 7'b0110011, 0);
    applyStimulus(0, 7'b0000011, 3);
    applyStimulus(0, 7'b1100111, 0);
    applyStimulus(0, 7'b0100011, 2);
    for (int i = 0; i < 40; i++) applyStimulus(0, legal_ops[$urandom_range(0, 9)], -1);

    // Reset lands while a store is waiting for memory.
    a_op = 7'b0100011;
    stepState(0, 0, 0);
    stepState(0, 1, 0);
    stepState(0, 5, 0);
    a_ready = 1'b0;
    #1;
    checkState(0, 8, 1'b0);
    @(posedge clk);
    @(negedge clk);
    doReset(0, 8);

    applyStimulus(0, 7'b1111111, 0);
    doReset(0, 15);
    a_reset = 1'b1;

    doReset(1, -1);
    applyStimulus(1, 7'b1111111, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 7'b0010011, 2);
      if (i == 14) checkOutput("u1 instret at 15", 32'(b_instret), 32'd15);
    end
    checkOutput("u1 instret wrapped", 32'(b_instret), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 7'($urandom_range(0, 127)), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
